// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with blanking and leading-zero suppression.
// Define SEG7_HEX_DECODE_EN to show codes 10..15 as A,b,C,d,E,F instead of "0".
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
`ifdef SEG7_HEX_DECODE_EN
            4'd10:   return 7'h77;
            4'd11:   return 7'h7C;
            4'd12:   return 7'h39;
            4'd13:   return 7'h5E;
            4'd14:   return 7'h79;
            4'd15:   return 7'h71;
`endif
            default: return 7'h3F;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0] shadow_val_r;
    logic [NUM_DIGITS-1:0]   shadow_dp_r;
    logic [CW-1:0]           cnt_r;
    logic [IW-1:0]           idx_r;

    logic [NUM_DIGITS-1:0]   zero_tail_s;
    logic [3:0]              cur_code_s;
    logic                    blank_s;
    logic [6:0]              seg_nxt_s;
    logic                    dp_nxt_s;
    logic [NUM_DIGITS-1:0]   an_nxt_s;

    // zero_tail_s[i]: digits i..NUM_DIGITS-1 of the shadow value are all zero
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_tail
        assign zero_tail_s[g] = (shadow_val_r[4*NUM_DIGITS-1:4*g] == {(4*(NUM_DIGITS-g)){1'b0}});
    end

    // Blank decision: the first cycle of each slot, or a suppressed leading zero
    always_comb begin
        cur_code_s = shadow_val_r[{idx_r, 2'b00} +: 4];
        if (cnt_r == {CW{1'b0}}) begin
            blank_s = 1'b1;
        end else if (lz_en && (idx_r != {IW{1'b0}})) begin
            blank_s = zero_tail_s[idx_r];
        end else begin
            blank_s = 1'b0;
        end
    end

    // Next output pattern for the current scan position
    always_comb begin
        an_nxt_s  = {NUM_DIGITS{1'b1}};
        seg_nxt_s = 7'h7F;
        dp_nxt_s  = 1'b1;
        if (!blank_s) begin
            an_nxt_s[idx_r] = 1'b0;
            seg_nxt_s       = ~decode(cur_code_s);
            dp_nxt_s        = ~shadow_dp_r[idx_r];
        end else begin
            an_nxt_s  = {NUM_DIGITS{1'b1}};
            seg_nxt_s = 7'h7F;
            dp_nxt_s  = 1'b1;
        end
    end

    // Shadow capture, prescaler/digit scan and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_val_r <= {(4*NUM_DIGITS){1'b0}};
            shadow_dp_r  <= {NUM_DIGITS{1'b0}};
            cnt_r        <= {CW{1'b0}};
            idx_r        <= {IW{1'b0}};
            seg_n        <= 7'h7F;
            dp_n         <= 1'b1;
            an_n         <= {NUM_DIGITS{1'b1}};
            frame_done   <= 1'b0;
        end else begin
            if (load) begin
                shadow_val_r <= value;
                shadow_dp_r  <= dp_in;
            end
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CW{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IW{1'b0}};
                end else begin
                    idx_r <= idx_r + 1'b1;
                end
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
            frame_done <= (cnt_r == CNT_LAST) && (idx_r == IDX_LAST);
            seg_n      <= seg_nxt_s;
            dp_n       <= dp_nxt_s;
            an_n       <= an_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        lz_en = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .lz_en(lz_en), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " seg_n"}, {25'd0, seg_n}, 32'h7F);
        chk({tag, " dp_n"}, {31'd0, dp_n}, 32'h1);
        chk({tag, " an_n"}, {28'd0, an_n}, 32'hF);
        chk({tag, " frame_done"}, {31'd0, frame_done}, 32'h0);
    endtask

    // Walks one 16-cycle frame; the caller has just observed the digit-0 blank slot.
    task automatic check_frame(input int fid, input logic [6:0] p0, input logic [6:0] p1,
                               input logic [6:0] p2, input logic [6:0] p3,
                               input logic [3:0] lit, input logic [3:0] dp);
        logic [6:0] pat [4];
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        int         slot;
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) step();
            slot = c / 4;
            if ((c % 4) == 0 || !lit[slot]) begin
                exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
            end else begin
                exp_an = ~(4'b0001 << slot); exp_seg = ~pat[slot]; exp_dp = ~dp[slot];
            end
            chk($sformatf("f%0d c%0d an_n", fid, c), {28'd0, an_n}, {28'd0, exp_an});
            chk($sformatf("f%0d c%0d seg_n", fid, c), {25'd0, seg_n}, {25'd0, exp_seg});
            chk($sformatf("f%0d c%0d dp_n", fid, c), {31'd0, dp_n}, {31'd0, exp_dp});
            chk($sformatf("f%0d c%0d frame_done", fid, c), {31'd0, frame_done}, (c == 15) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk_reset_outputs("reset");

        // 1234 with a dp on digit 1
        reset = 1'b0; load = 1'b1; value = 16'h1234; dp_in = 4'b0010; lz_en = 1'b0;
        step();
        load = 1'b0;
        check_frame(1, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b1111, 4'b0010);

        // 0070 with leading-zero suppression
        load = 1'b1; value = 16'h0070; dp_in = 4'b0000; lz_en = 1'b1;
        step();
        load = 1'b0;
        check_frame(2, 7'h3F, 7'h07, 7'h3F, 7'h3F, 4'b0011, 4'b0000);

        // Same value, suppression off (lz_en is live)
        lz_en = 1'b0;
        step();
        check_frame(3, 7'h3F, 7'h07, 7'h3F, 7'h3F, 4'b1111, 4'b0000);

        // All zero, suppressed digit 2 hides its dp
        load = 1'b1; value = 16'h0000; dp_in = 4'b0100; lz_en = 1'b1;
        step();
        load = 1'b0;
        check_frame(4, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0001, 4'b0100);

        // Hex codes count as nonzero for suppression
        load = 1'b1; value = 16'h00AF; dp_in = 4'b0000; lz_en = 1'b1;
        step();
        load = 1'b0;
`ifdef SEG7_HEX_DECODE_EN
        check_frame(5, 7'h71, 7'h77, 7'h3F, 7'h3F, 4'b0011, 4'b0000);
`else
        check_frame(5, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0011, 4'b0000);
`endif

        // Mid-slot load during digit 2
        lz_en = 1'b0;
        step();
        repeat (9) step();
        chk("d2 before load an_n", {28'd0, an_n}, 32'hB);
        chk("d2 before load seg_n", {25'd0, seg_n}, {25'd0, ~7'h3F});
        load = 1'b1; value = 16'h5555;
        step();
        load = 1'b0;
        chk("load edge an_n", {28'd0, an_n}, 32'hB);
        chk("load edge seg_n", {25'd0, seg_n}, {25'd0, ~7'h3F});
        step();
        chk("after load an_n", {28'd0, an_n}, 32'hB);
        chk("after load seg_n", {25'd0, seg_n}, {25'd0, ~7'h6D});

        // Reset mid-frame with a simultaneous load: reset wins
        reset = 1'b1; load = 1'b1; value = 16'h9999;
        step();
        chk_reset_outputs("midreset");
        reset = 1'b0; load = 1'b0;
        step();
        chk("restart blank an_n", {28'd0, an_n}, 32'hF);
        chk("restart blank seg_n", {25'd0, seg_n}, 32'h7F);
        step();
        chk("restart d0 an_n", {28'd0, an_n}, 32'hE);
        chk("restart d0 seg_n", {25'd0, seg_n}, {25'd0, ~7'h3F});
        chk("restart d0 dp_n", {31'd0, dp_n}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
